// File: rtl/sdrc_wbm_pkg.sv
// sdrc_wbm_pkg
// Shared types and constants for the Wishbone burst initiator that feeds
// the SDRAM controller's Wishbone slave port.
//   wbm_state_e : burst sequencer states
//   CTI_*       : Wishbone cycle type identifiers used on wb_cti_o
//   ADDR_STEP   : byte increment between beats of an incrementing burst
package sdrc_wbm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        FIN  = 2'd3
    } wbm_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int ADDR_STEP = 4;

endpackage

// File: rtl/sdrc_wb_master_if.sv
// sdrc_wb_master_if
// Wishbone bus bundle between the burst initiator (master) and the SDRAM
// controller's slave port.
//   wb_cyc_o, wb_stb_o, wb_we_o : cycle, strobe, write enable
//   wb_addr_o [APP_AW]          : byte address
//   wb_dat_o  [DW]              : write data
//   wb_sel_o  [DW/8]            : byte lane selects
//   wb_cti_o  [3]               : cycle type identifier
//   wb_ack_i, wb_dat_i [DW]     : acknowledge and read data from the slave
interface sdrc_wb_master_if #(
    parameter int APP_AW = 26,
    parameter int DW     = 32
) ();

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [APP_AW-1:0] wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/sdrc_wbm_timeout.sv
// sdrc_wbm_timeout
// Ack watchdog for the burst initiator. Counts cycles in which a strobe is
// outstanding without an acknowledge; any ack or leaving the burst clears it.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the counter at zero (master not in a burst)
//   stb, ack   : strobe presented / strobe acknowledged this cycle
//   expired    : counter has reached TIMEOUT_CYC
module sdrc_wbm_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic stb,
    input  logic ack,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] wait_cnt;

    // Saturating counter so a very long stall can never wrap back below the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 16'd0;
        end else if (clear || ack) begin
            wait_cnt <= 16'd0;
        end else if (stb && (wait_cnt != 16'hFFFF)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign expired = (wait_cnt >= LIMIT);

endmodule

// File: rtl/sdrc_wb_master.sv
// sdrc_wb_master
// Wishbone burst initiator driving the SDRAM controller's slave port.
// Accepts read/write burst commands on a valid/ready port and runs them as
// incrementing Wishbone bursts; write data is pulled from a stream, read
// data is pushed out on a stream without backpressure.
//   wb_clk_i, wb_resetn         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_we, cmd_addr, cmd_len   : direction, start byte address, beats (0 = 256)
//   wdata_valid/wdata_ready/wdata : write data stream (consumed on ack)
//   rdata_valid, rdata          : read data stream, one cycle after each ack
//   done                        : pulse after the last beat of a burst
//   err                         : pulse when a burst is aborted by the watchdog
//   wb                          : Wishbone master bundle
// Optional feature macro: SDRC_WBM_TIMEOUT_EN enables the ack watchdog
// (limit TIMEOUT_CYC); without it the master waits indefinitely for acks.
module sdrc_wb_master
    import sdrc_wbm_pkg::*;
#(
    parameter int APP_AW      = 26,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DW-1:0]     wdata,
    output logic              rdata_valid,
    output logic [DW-1:0]     rdata,
    output logic              done,
    output logic              err,
    sdrc_wb_master_if.master  wb
);

    localparam logic [APP_AW-1:0] ADDR_MASK = ~APP_AW'(3);
    localparam logic [APP_AW-1:0] STEP      = APP_AW'(ADDR_STEP);

    wbm_state_e        state, state_next;
    logic              we_q;
    logic [APP_AW-1:0] addr_q;
    logic [8:0]        beat_cnt;
    logic [DW-1:0]     rdata_q;
    logic              rdata_valid_q;

    logic              cyc, stb, bus_ack, abort, timeout;
    logic [2:0]        cti;
    logic [DW-1:0]     dat_out;

    wire busy = (state == WR) || (state == RD);
    wire last = (beat_cnt == 9'd1);

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ack only counts while a strobe is out; in WR the strobe follows wdata_valid.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        cyc         = 1'b0;
        stb         = 1'b0;
        cti         = CTI_CLASSIC;
        done        = 1'b0;
        wdata_ready = 1'b0;
        dat_out     = '0;
        bus_ack     = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = wb_resetn;
                if (cmd_valid) begin
                    state_next = cmd_we ? WR : RD;
                end
            end
            WR: begin
                cyc         = 1'b1;
                stb         = wdata_valid;
                dat_out     = wdata;
                cti         = last ? CTI_EOB : CTI_INCR;
                bus_ack     = wb.wb_ack_i && wdata_valid;
                wdata_ready = bus_ack;
                abort       = timeout && !bus_ack;
                if (bus_ack && last) begin
                    state_next = FIN;
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            RD: begin
                cyc     = 1'b1;
                stb     = 1'b1;
                cti     = last ? CTI_EOB : CTI_INCR;
                bus_ack = wb.wb_ack_i;
                abort   = timeout && !bus_ack;
                if (bus_ack && last) begin
                    state_next = FIN;
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch and per-beat address/count advance; address wraps at 2^APP_AW.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            beat_cnt <= 9'd0;
        end else if ((state == IDLE) && cmd_valid) begin
            we_q     <= cmd_we;
            addr_q   <= cmd_addr & ADDR_MASK;
            beat_cnt <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
        end else if (bus_ack) begin
            addr_q   <= addr_q + STEP;
            beat_cnt <= beat_cnt - 9'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= (state == RD) && bus_ack;
            if ((state == RD) && bus_ack) begin
                rdata_q <= wb.wb_dat_i;
            end
        end
    end

`ifdef SDRC_WBM_TIMEOUT_EN
    logic err_q;

    sdrc_wbm_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_resetn),
        .clear   (!busy),
        .stb     (stb),
        .ack     (bus_ack),
        .expired (timeout)
    );

    // err lines up with the cycle in which cyc has already dropped.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign err = err_q;
`else
    logic [15:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 16'(TIMEOUT_CYC);
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

    assign wb.wb_cyc_o  = cyc;
    assign wb.wb_stb_o  = stb;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_dat_o  = dat_out;
    assign wb.wb_sel_o  = {(DW/8){cyc}};
    assign wb.wb_cti_o  = cti;

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_sdrc_wb_master.sv
// tb_sdrc_wb_master
// Directed bench for sdrc_wb_master: write burst, read back, write-data
// stall, length/address wrap, ack stall (watchdog when SDRC_WBM_TIMEOUT_EN
// is defined) and asynchronous reset mid-burst. A small zero-wait slave
// model with a 256-word memory answers the bus.
module tb_sdrc_wb_master;

    localparam int APP_AW = 26;
    localparam int DW     = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready, cmd_we;
    logic [APP_AW-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wdata_valid, wdata_ready;
    logic [DW-1:0]     wdata;
    logic              rdata_valid;
    logic [DW-1:0]     rdata;
    logic              done, err;

    logic              slave_en;
    logic [DW-1:0]     mem [0:255];
    int                ack_total = 0;
    int                rv_total  = 0;

    int compared   = 0;
    int mismatched = 0;

    sdrc_wb_master_if #(.APP_AW(APP_AW), .DW(DW)) wb_bus ();

    sdrc_wb_master #(
        .APP_AW      (APP_AW),
        .DW          (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .wb_clk_i    (clk),
        .wb_resetn   (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .wb          (wb_bus)
    );

    always #5 clk = ~clk;

    // Zero-wait slave: acks every strobe in the same cycle when enabled.
    always_comb wb_bus.wb_ack_i = slave_en & wb_bus.wb_stb_o;
    always_comb wb_bus.wb_dat_i = mem[wb_bus.wb_addr_o[9:2]];

    always @(posedge clk) begin
        if (wb_bus.wb_cyc_o && wb_bus.wb_stb_o && wb_bus.wb_ack_i) begin
            ack_total <= ack_total + 1;
            if (wb_bus.wb_we_o) begin
                mem[wb_bus.wb_addr_o[9:2]] <= wb_bus.wb_dat_o;
            end
        end
        if (rdata_valid) begin
            rv_total <= rv_total + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Offers one command for a single cycle; returns at the negedge of the first bus cycle.
    task automatic applyStimulus(input logic we, input logic [APP_AW-1:0] addr, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int acks0;
        int rv0;
        logic [APP_AW-1:0] exp_addr;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = '0;
        cmd_len     = 8'd0;
        wdata_valid = 1'b0;
        wdata       = '0;
        slave_en    = 1'b1;

        // Reset state
        #2;
        checkOutput("rst_cyc", 64'(wb_bus.wb_cyc_o), 64'd0);
        checkOutput("rst_stb", 64'(wb_bus.wb_stb_o), 64'd0);
        checkOutput("rst_cti", 64'(wb_bus.wb_cti_o), 64'd0);
        checkOutput("rst_addr", 64'(wb_bus.wb_addr_o), 64'd0);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_rdata_valid", 64'(rdata_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write burst: 4 beats at 0x100 with data 0xA0..0xA3
        $display("[TB] write burst");
        wdata_valid = 1'b1;
        wdata       = 32'hA0;
        acks0       = ack_total;
        applyStimulus(1'b1, 26'h100, 8'd4);
        for (int i = 0; i < 4; i++) begin
            wdata = 32'hA0 + 32'(i);
            #1;
            checkOutput("wr_cyc", 64'(wb_bus.wb_cyc_o), 64'd1);
            checkOutput("wr_stb", 64'(wb_bus.wb_stb_o), 64'd1);
            checkOutput("wr_we", 64'(wb_bus.wb_we_o), 64'd1);
            checkOutput("wr_sel", 64'(wb_bus.wb_sel_o), 64'hF);
            checkOutput("wr_addr", 64'(wb_bus.wb_addr_o), 64'h100 + 64'(4 * i));
            checkOutput("wr_cti", 64'(wb_bus.wb_cti_o), (i == 3) ? 64'b111 : 64'b010);
            checkOutput("wr_dat", 64'(wb_bus.wb_dat_o), 64'hA0 + 64'(i));
            checkOutput("wr_wdata_ready", 64'(wdata_ready), 64'd1);
            checkOutput("wr_cmd_ready", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("wr_done", 64'(done), 64'd1);
        checkOutput("wr_fin_cyc", 64'(wb_bus.wb_cyc_o), 64'd0);
        checkOutput("wr_fin_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("wr_fin_wdata_ready", 64'(wdata_ready), 64'd0);
        checkOutput("wr_acks", 64'(ack_total - acks0), 64'd4);
        @(negedge clk);
        wdata_valid = 1'b0;
        #1;
        checkOutput("wr_done_clear", 64'(done), 64'd0);
        checkOutput("wr_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("mem_0x100", 64'(mem[64]), 64'hA0);
        checkOutput("mem_0x10C", 64'(mem[67]), 64'hA3);

        // Read back the same 4 words
        $display("[TB] read back");
        rv0 = rv_total;
        applyStimulus(1'b0, 26'h100, 8'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("rd_stb", 64'(wb_bus.wb_stb_o), 64'd1);
            checkOutput("rd_we", 64'(wb_bus.wb_we_o), 64'd0);
            checkOutput("rd_addr", 64'(wb_bus.wb_addr_o), 64'h100 + 64'(4 * i));
            checkOutput("rd_cti", 64'(wb_bus.wb_cti_o), (i == 3) ? 64'b111 : 64'b010);
            checkOutput("rd_valid", 64'(rdata_valid), (i == 0) ? 64'd0 : 64'd1);
            if (i > 0) begin
                checkOutput("rd_data", 64'(rdata), 64'hA0 + 64'(i - 1));
            end
            @(negedge clk);
        end
        #1;
        checkOutput("rd_done", 64'(done), 64'd1);
        checkOutput("rd_last_valid", 64'(rdata_valid), 64'd1);
        checkOutput("rd_last_data", 64'(rdata), 64'hA3);
        @(negedge clk);
        #1;
        checkOutput("rd_valid_clear", 64'(rdata_valid), 64'd0);
        checkOutput("rd_pulses", 64'(rv_total - rv0), 64'd4);

        // Write-data stall of 3 cycles after beat 1
        $display("[TB] write stall");
        wdata_valid = 1'b1;
        wdata       = 32'hB0;
        acks0       = ack_total;
        applyStimulus(1'b1, 26'h200, 8'd4);
        #1;
        checkOutput("st_b0_addr", 64'(wb_bus.wb_addr_o), 64'h200);
        checkOutput("st_b0_stb", 64'(wb_bus.wb_stb_o), 64'd1);
        @(negedge clk);
        wdata_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checkOutput("st_wait_stb", 64'(wb_bus.wb_stb_o), 64'd0);
            checkOutput("st_wait_cyc", 64'(wb_bus.wb_cyc_o), 64'd1);
            checkOutput("st_wait_cti", 64'(wb_bus.wb_cti_o), 64'b010);
            checkOutput("st_wait_addr", 64'(wb_bus.wb_addr_o), 64'h204);
            checkOutput("st_wait_wready", 64'(wdata_ready), 64'd0);
            @(negedge clk);
        end
        for (int i = 1; i < 4; i++) begin
            wdata_valid = 1'b1;
            wdata       = 32'hB0 + 32'(i);
            #1;
            checkOutput("st_addr", 64'(wb_bus.wb_addr_o), 64'h200 + 64'(4 * i));
            checkOutput("st_cti", 64'(wb_bus.wb_cti_o), (i == 3) ? 64'b111 : 64'b010);
            checkOutput("st_stb", 64'(wb_bus.wb_stb_o), 64'd1);
            @(negedge clk);
        end
        #1;
        checkOutput("st_done", 64'(done), 64'd1);
        checkOutput("st_fin_wready", 64'(wdata_ready), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("st_idle_wready", 64'(wdata_ready), 64'd0);
        checkOutput("st_acks", 64'(ack_total - acks0), 64'd4);
        checkOutput("mem_0x204", 64'(mem[129]), 64'hB1);
        checkOutput("mem_0x20C", 64'(mem[131]), 64'hB3);
        wdata_valid = 1'b0;

        // Length 0 (256 beats) starting 8 bytes below the top of the address space
        $display("[TB] length/address wrap");
        acks0    = ack_total;
        exp_addr = 26'h3FFFFF8;
        applyStimulus(1'b0, 26'h3FFFFF8, 8'd0);
        for (int i = 0; i < 256; i++) begin
            #1;
            checkOutput("wrap_addr", 64'(wb_bus.wb_addr_o), 64'(exp_addr));
            checkOutput("wrap_cti", 64'(wb_bus.wb_cti_o), (i == 255) ? 64'b111 : 64'b010);
            if (i == 2) begin
                checkOutput("wrap_to_zero", 64'(wb_bus.wb_addr_o), 64'h0);
            end
            exp_addr = exp_addr + 26'd4;
            @(negedge clk);
        end
        #1;
        checkOutput("wrap_done", 64'(done), 64'd1);
        checkOutput("wrap_acks", 64'(ack_total - acks0), 64'd256);
        checkOutput("wrap_end_addr", 64'(wb_bus.wb_addr_o), 64'h3F8);
        @(negedge clk);

        // Slave that never acks
        slave_en = 1'b0;
`ifdef SDRC_WBM_TIMEOUT_EN
        $display("[TB] ack timeout");
        applyStimulus(1'b0, 26'h40, 8'd8);
        for (int j = 0; j < 17; j++) begin
            #1;
            checkOutput("to_wait_cyc", 64'(wb_bus.wb_cyc_o), 64'd1);
            checkOutput("to_wait_err", 64'(err), 64'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("to_err", 64'(err), 64'd1);
        checkOutput("to_cyc", 64'(wb_bus.wb_cyc_o), 64'd0);
        checkOutput("to_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("to_no_done", 64'(done), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("to_err_clear", 64'(err), 64'd0);
`else
        $display("[TB] ack stall without watchdog");
        applyStimulus(1'b0, 26'h40, 8'd8);
        for (int j = 0; j < 40; j++) begin
            #1;
            checkOutput("hold_cyc", 64'(wb_bus.wb_cyc_o), 64'd1);
            checkOutput("hold_err", 64'(err), 64'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Asynchronous reset in the middle of a burst
        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, 26'h80, 8'd4);
        #1;
        checkOutput("mr_cyc_before", 64'(wb_bus.wb_cyc_o), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mr_cyc", 64'(wb_bus.wb_cyc_o), 64'd0);
        checkOutput("mr_stb", 64'(wb_bus.wb_stb_o), 64'd0);
        checkOutput("mr_cti", 64'(wb_bus.wb_cti_o), 64'd0);
        checkOutput("mr_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("mr_done", 64'(done), 64'd0);
        checkOutput("mr_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        slave_en = 1'b1;
        #1;
        checkOutput("mr_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("mr_idle_cyc", 64'(wb_bus.wb_cyc_o), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("mr_no_done", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
